sram_64x16384_req_ctrl: RTL and testbench

SRAM_64X16384_REQ_CTRL -- requirements
Module: sram_64x16384_req_ctrl

---
 rtl/sram_64x16384_req_ctrl.sv | 101 ++++++++++
 tb/tb_sram_64x16384_req_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sram_64x16384_req_ctrl.sv
// Valid/ready request front end for a 64x16384 SRAM macro with an in-order read response buffer.
// Read data appears 2 cycles after accept; req_ready drops once buffered plus in-flight reads would fill the buffer.
module sram_64x16384_req_ctrl #(
  parameter int BITS       = 64,
  parameter int ADDR_WIDTH = 14,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BITS-1:0]       req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BITS-1:0]       resp_rdata,
  output logic                  sram_ce_in,
  output logic                  sram_we_in,
  output logic [ADDR_WIDTH-1:0] sram_addr_in,
  output logic [BITS-1:0]       sram_wd_in,
  output logic [BITS-1:0]       sram_w_mask_in,
  input  logic [BITS-1:0]       sram_rd_out,
  output logic                  busy
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int SW = CW + 1;

  logic [BITS-1:0] resp_mem [RESP_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            rd_inflight;
  logic            accept;
  logic            push;
  logic            pop;
  logic [SW-1:0]   credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign resp_valid  = (count != '0);
  assign resp_rdata  = resp_mem[rd_ptr];
  assign pop         = resp_valid && resp_ready;
  assign push        = rd_inflight;
  assign busy        = rd_inflight || resp_valid;

  // Every read already accepted but not yet popped holds a slot; a slot freed this cycle may be reused.
  assign credit_used = SW'(count) + SW'(rd_inflight) - SW'(pop);
  assign req_ready   = !reset && (credit_used < SW'(RESP_DEPTH));
  assign accept      = req_valid && req_ready;

  always_comb begin
    sram_ce_in     = 1'b0;
    sram_we_in     = 1'b0;
    sram_addr_in   = '0;
    sram_wd_in     = '0;
    sram_w_mask_in = '0;
    if (accept) begin
      sram_ce_in     = 1'b1;
      sram_we_in     = req_write;
      sram_addr_in   = req_addr;
      sram_wd_in     = req_wdata;
      sram_w_mask_in = req_wmask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= accept && !req_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never visible while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) resp_mem[wr_ptr] <= sram_rd_out;
  end

endmodule

// File: tb/tb_sram_64x16384_req_ctrl.sv
// Bench for sram_64x16384_req_ctrl: directed scenarios then random traffic against a queue-based reference.
module tb_sram_64x16384_req_ctrl;

  localparam int DEPTH = 2;
  localparam int WORDS = 16384;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [13:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        sram_ce_in;
  logic        sram_we_in;
  logic [13:0] sram_addr_in;
  logic [63:0] sram_wd_in;
  logic [63:0] sram_w_mask_in;
  logic [63:0] sram_rd_out;
  logic        busy;

  sram_64x16384_req_ctrl #(.BITS(64), .ADDR_WIDTH(14), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .sram_ce_in(sram_ce_in), .sram_we_in(sram_we_in), .sram_addr_in(sram_addr_in),
    .sram_wd_in(sram_wd_in), .sram_w_mask_in(sram_w_mask_in),
    .sram_rd_out(sram_rd_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model driven only by the DUT's sram_* pins.
  logic [63:0] macro_mem [WORDS];
  logic [63:0] macro_rd;
  assign sram_rd_out = macro_rd;
  always @(posedge clk) begin
    if (sram_ce_in) begin
      if (sram_we_in)
        macro_mem[sram_addr_in] <= (macro_mem[sram_addr_in] & ~sram_w_mask_in) | (sram_wd_in & sram_w_mask_in);
      else
        macro_rd <= macro_mem[sram_addr_in];
    end
  end

  // Reference: memory updated from requests at accept, plus a queue of read results and their accept cycles.
  logic [63:0] ref_mem [WORDS];
  logic [63:0] q_d [$];
  int          q_t [$];
  int          cyc;
  int          n_vec;
  int          n_miscmp;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic do_cycle(input bit v, input bit w, input logic [13:0] a,
                          input logic [63:0] d, input logic [63:0] m, input bit rr);
    bit vld_e, pop_e, rdy_e, acc_e;
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_wmask  = m;
    resp_ready = rr;
    @(negedge clk);
    if (reset) begin
      q_d.delete();
      q_t.delete();
    end
    vld_e = (q_d.size() != 0) && (cyc >= q_t[0] + 2);
    pop_e = vld_e && rr;
    rdy_e = !reset && ((q_d.size() - int'(pop_e)) < DEPTH);
    acc_e = v && rdy_e;
    chk_eq("req_ready",  {63'd0, req_ready},  {63'd0, rdy_e});
    chk_eq("resp_valid", {63'd0, resp_valid}, {63'd0, vld_e});
    if (vld_e) chk_eq("resp_rdata", resp_rdata, q_d[0]);
    chk_eq("busy",       {63'd0, busy},       {63'd0, q_d.size() != 0});
    chk_eq("sram_ce",    {63'd0, sram_ce_in}, {63'd0, acc_e});
    chk_eq("sram_we",    {63'd0, sram_we_in}, {63'd0, acc_e && w});
    chk_eq("sram_addr",  {50'd0, sram_addr_in}, acc_e ? {50'd0, a} : 64'd0);
    chk_eq("sram_wd",    sram_wd_in,     acc_e ? d : 64'd0);
    chk_eq("sram_mask",  sram_w_mask_in, acc_e ? m : 64'd0);
    if (pop_e) begin
      void'(q_d.pop_front());
      void'(q_t.pop_front());
    end
    if (acc_e) begin
      if (w) begin
        ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
      end else begin
        q_d.push_back(ref_mem[a]);
        q_t.push_back(cyc);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 14'd0, 64'd0, 64'd0, rr);
  endtask

  initial begin
    logic [63:0] init_w;
    cyc = 0; n_vec = 0; n_miscmp = 0;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;
    macro_rd = '0;
    for (int i = 0; i < WORDS; i++) begin
      init_w = {$urandom, $urandom};
      macro_mem[i] = init_w;
      ref_mem[i]   = init_w;
    end
    @(posedge clk); #1;

    // Reset hold, with requests offered that must be ignored.
    do_cycle(1'b1, 1'b0, 14'h0005, 64'h1, 64'h1, 1'b1);
    do_cycle(1'b1, 1'b1, 14'h0006, 64'h2, 64'h3, 1'b1);
    reset = 1'b0;

    // Write then read, then masked write then read.
    do_cycle(1'b1, 1'b1, 14'h0005, 64'hDEADBEEF_01234567, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
    do_cycle(1'b1, 1'b0, 14'h0005, 64'h0, 64'h0, 1'b1);
    idle(4, 1'b1);
    do_cycle(1'b1, 1'b1, 14'h0005, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_FFFFFFFF, 1'b1);
    do_cycle(1'b1, 1'b0, 14'h0005, 64'h0, 64'h0, 1'b1);
    idle(4, 1'b1);

    // Streaming reads 0..7.
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 14'(i), 64'h0, 64'h0, 1'b1);
    idle(4, 1'b1);

    // Backpressure: only two reads fit, then drain and resume.
    for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 14'(10 + i), 64'h0, 64'h0, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 14'(20 + i), 64'h0, 64'h0, 1'b1);
    idle(4, 1'b1);

    // Reset the cycle after a read accept.
    do_cycle(1'b1, 1'b0, 14'h0005, 64'h0, 64'h0, 1'b1);
    reset = 1'b1;
    idle(1, 1'b1);
    reset = 1'b0;
    idle(4, 1'b1);

    // Address extremes.
    do_cycle(1'b1, 1'b1, 14'h3FFF, 64'hA5A5A5A5_3FFF3FFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
    do_cycle(1'b1, 1'b1, 14'h0000, 64'h5A5A5A5A_00000000, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
    do_cycle(1'b1, 1'b0, 14'h3FFF, 64'h0, 64'h0, 1'b1);
    do_cycle(1'b1, 1'b0, 14'h0000, 64'h0, 64'h0, 1'b1);
    idle(4, 1'b1);

    // Random traffic with backpressure, stalled-request churn and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      logic [13:0] a;
      a = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
      reset = ($urandom_range(0, 99) == 0);
      do_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, a,
               {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 9) < 6);
    end
    reset = 1'b0;
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
